// File: rtl/seq_divmod_unit.sv
// seq_divmod_unit: sequential unsigned divider, restoring shift-subtract,
// one quotient bit per clock. Started by a rising edge on go.
//   clk, rst_n : clock, asynchronous active-low reset
//   go         : start request (rising edge starts a division)
//   a, b       : dividend / divisor, sampled on the start edge
//   ready      : high in IDLE/DONE/ERROR, low while a division runs
//   error      : high when the last requested division had b == 0
//   div, mod   : quotient / remainder of the last completed division
module seq_divmod_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             error,
    output logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] mod
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        BUSY,
        DIV0,
        DONE,
        ERROR
    } state_t;

    state_t           state_q, state_d;
    logic             go_prev_q;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic             ready_q, ready_d;
    logic             error_q, error_d;

    logic             start;
    logic [WIDTH:0]   t;
    logic             q_bit;

    assign start = go && !go_prev_q;
    // Partial remainder with the next dividend bit shifted in.
    assign t     = {r_q, a_q[WIDTH-1]};
    assign q_bit = (t >= {1'b0, b_q});

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        mod_d   = mod_q;
        ready_d = ready_q;
        error_d = error_q;

        if (start) begin
            // Accepted in every state; an in-flight division is discarded.
            a_d     = a;
            b_d     = b;
            r_d     = '0;
            cnt_d   = CW'(WIDTH);
            ready_d = 1'b0;
            error_d = 1'b0;
            state_d = (b == '0) ? DIV0 : BUSY;
        end else begin
            unique case (state_q)
                BUSY: begin
                    // Remainder stays below b, so the low WIDTH bits suffice.
                    r_d   = q_bit ? (t[WIDTH-1:0] - b_q) : t[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], q_bit};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        div_d   = a_d;
                        mod_d   = r_d;
                        ready_d = 1'b1;
                        state_d = DONE;
                    end
                end
                DIV0: begin
                    div_d   = '1;
                    mod_d   = a_q;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    state_d = ERROR;
                end
                IDLE, DONE, ERROR: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            go_prev_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            div_q     <= '0;
            mod_q     <= '0;
            ready_q   <= 1'b1;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            go_prev_q <= go;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            mod_q     <= mod_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
        end
    end

    assign ready = ready_q;
    assign error = error_q;
    assign div   = div_q;
    assign mod   = mod_q;

endmodule

// File: tb/tb_seq_divmod_unit.sv
// Testbench for seq_divmod_unit: directed vectors, a latency/arithmetic
// model checked every cycle, plus literal expectations per vector.
module tb_seq_divmod_unit;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst_n;
    logic         go;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         error;
    logic [W-1:0] div;
    logic [W-1:0] mod;

    int total = 0;
    int bad   = 0;

    seq_divmod_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go),
        .a     (a),
        .b     (b),
        .ready (ready),
        .error (error),
        .div   (div),
        .mod   (mod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: results from plain arithmetic, visible after a
    // fixed latency (W cycles, or 1 cycle for divide-by-zero).
    logic         m_go_prev, m_ready, m_error;
    logic [W-1:0] m_div, m_mod, p_div, p_mod;
    logic         p_err;
    int           m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_go_prev <= 1'b0;
            m_ready   <= 1'b1;
            m_error   <= 1'b0;
            m_div     <= '0;
            m_mod     <= '0;
            m_pend    <= 0;
        end else begin
            m_go_prev <= go;
            if (go && !m_go_prev) begin
                m_ready <= 1'b0;
                m_error <= 1'b0;
                p_err   <= (b == 0);
                p_div   <= (b == 0) ? '1 : a / b;
                p_mod   <= (b == 0) ? a : a % b;
                m_pend  <= (b == 0) ? 1 : W;
            end else if (m_pend > 0) begin
                m_pend <= m_pend - 1;
                if (m_pend == 1) begin
                    m_ready <= 1'b1;
                    m_error <= p_err;
                    m_div   <= p_div;
                    m_mod   <= p_mod;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_ready", 32'(ready), 32'(m_ready));
            check("cyc_error", 32'(error), 32'(m_error));
            check("cyc_div", 32'(div), 32'(m_div));
            check("cyc_mod", 32'(mod), 32'(m_mod));
        end
    end

    // Pulse go for one cycle; returns at the negedge after the start edge.
    task automatic pulse(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        a  = av;
        b  = bv;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    // Cycles from the post-start negedge until ready is seen high.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", 32'(n), 32'd0);
    endtask

    task automatic run(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input int lat, input logic [W-1:0] ed, input logic [W-1:0] em,
                       input logic ee);
        int n;
        pulse(av, bv);
        check({name, "_busy"}, 32'(ready), 32'd0);
        wait_ready(n);
        check({name, "_lat"}, 32'(n), 32'(lat));
        check({name, "_div"}, 32'(div), 32'(ed));
        check({name, "_mod"}, 32'(mod), 32'(em));
        check({name, "_err"}, 32'(error), 32'(ee));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        go    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_error", 32'(error), 32'd0);
        check("rst_div", 32'(div), 32'd0);
        check("rst_mod", 32'(mod), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run("d100_7", 16'd100, 16'd7, 16, 16'd14, 16'd2, 1'b0);
        run("d5_9", 16'd5, 16'd9, 16, 16'd0, 16'd5, 1'b0);
        run("dmax_1", 16'hFFFF, 16'd1, 16, 16'hFFFF, 16'd0, 1'b0);
        run("dmax_max", 16'hFFFF, 16'hFFFF, 16, 16'd1, 16'd0, 1'b0);
        run("d42_0", 16'd42, 16'd0, 1, 16'hFFFF, 16'd42, 1'b1);
        run("d9_3", 16'd9, 16'd3, 16, 16'd3, 16'd0, 1'b0);

        // Restart mid-division: second start 5 cycles after the first.
        pulse(16'd1000, 16'd3);
        repeat (4) @(negedge clk);
        run("abort", 16'd50, 16'd8, 16, 16'd6, 16'd2, 1'b0);

        // go held high: exactly one division.
        @(negedge clk);
        a  = 16'd81;
        b  = 16'd9;
        go = 1'b1;
        @(negedge clk);
        check("hold_busy", 32'(ready), 32'd0);
        wait_ready(n);
        check("hold_lat", 32'(n), 32'd16);
        repeat (40 - n) @(negedge clk);
        check("hold_ready", 32'(ready), 32'd1);
        check("hold_div", 32'(div), 32'd9);
        check("hold_mod", 32'(mod), 32'd0);
        go = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a division.
        pulse(16'd1000, 16'd7);
        repeat (7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(ready), 32'd1);
        check("arst_error", 32'(error), 32'd0);
        check("arst_div", 32'(div), 32'd0);
        check("arst_mod", 32'(mod), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run("d17_5", 16'd17, 16'd5, 16, 16'd3, 16'd2, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
